// File: rtl/fir_mul_pkg.sv
// Shared definitions for the FIR tap multiplier: product width and the
// scale / round / saturate helper used by the output stage.
package fir_mul_pkg;

  // Full product width for the default 16-bit sample x 7-bit coefficient.
  localparam int PW = 23;

  // Working width of the scaling helper; products must fit with headroom.
  localparam int MW = 64;

  typedef struct packed {
    logic          ovf;
    logic [MW-1:0] dout;
  } sat_res_t;

  // Shift the signed product right (optionally rounding half up), then
  // either clamp or wrap into a dout_w-bit signed range. The caller keeps
  // the low dout_w bits of .dout.
  function automatic sat_res_t sat_shift(
    input logic signed [MW-1:0] p,
    input int                   shift,
    input bit                   round_en,
    input bit                   sat_en,
    input int                   dout_w
  );
    logic signed [MW-1:0] s;
    logic signed [MW-1:0] hi;
    logic signed [MW-1:0] lo;
    sat_res_t             r;
    s = p;
    if (round_en && shift > 0) begin
      s = s + (64'sd1 <<< (shift - 1));
    end
    s = s >>> shift;
    hi = (64'sd1 <<< (dout_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dout_w - 1));
    r.ovf = (s > hi) || (s < lo);
    if (sat_en && (s > hi)) begin
      r.dout = hi;
    end else if (sat_en && (s < lo)) begin
      r.dout = lo;
    end else begin
      r.dout = s;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_mul_pipe_reg.sv
// Enable-gated pipeline register with synchronous active-low clear.
// One instance per pipeline stage; the valid bit travels in the same word.
module fir_mul_pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Load new data only when the pipeline advances, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (en_i) begin
      data_d = d_i;
    end
  end

  // Stage storage; reset clears data and valid alike.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/fir_mul_pipe.sv
// Pipelined signed coefficient x sample multiplier with valid/ready flow
// control, right-shift scaling, optional rounding and saturation/wrap.
// The whole pipeline advances as one unit; bubbles are not collapsed.
module fir_mul_pipe
  import fir_mul_pkg::*;
#(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 7,
  parameter int DOUT_WIDTH = 23,
  parameter int NUM_STAGE  = 3,
  parameter int SHIFT      = 0,
  parameter int ROUND_EN   = 0,
  parameter int SAT_EN     = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  dout_ovf,
  output logic                  ovf_sticky,
  input  logic                  ovf_clr
);

  localparam int PROD_W  = DIN0_WIDTH + DIN1_WIDTH;
  localparam int NUM_DLY = (NUM_STAGE > 3) ? NUM_STAGE - 3 : 0;
  localparam int OUT_W   = DOUT_WIDTH + 2;

  // Refuse to elaborate with out-of-range parameters.
  if (DIN0_WIDTH < 1 || DIN1_WIDTH < 1 || PROD_W > MW - 2 ||
      DOUT_WIDTH < 2 || DOUT_WIDTH > PROD_W ||
      NUM_STAGE < 1 || NUM_STAGE > 8 ||
      SHIFT < 0 || SHIFT > PROD_W - 1 ||
      ROUND_EN < 0 || ROUND_EN > 1 || SAT_EN < 0 || SAT_EN > 1) begin : g_bad_param
    $fatal(1, "fir_mul_pipe: illegal parameter value");
  end

  // Single pipeline enable: move when the output slot is empty or drained.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Product and valid presented to the scale/saturate stage.
  logic signed [PROD_W-1:0] sc_p;
  logic                     sc_v;

  if (NUM_STAGE == 1) begin : g_one
    // Multiply, scale and saturate all land in the single output register.
    assign sc_v = in_valid;
    assign sc_p = PROD_W'($signed(din0)) * PROD_W'($signed(din1));
  end else begin : g_multi
    logic signed [DIN0_WIDTH-1:0] mul_a;
    logic signed [DIN1_WIDTH-1:0] mul_b;
    logic                         mul_v;
    logic [PROD_W:0]              dly_q [0:NUM_DLY];

    if (NUM_STAGE == 2) begin : g_no_in_reg
      assign mul_v = in_valid;
      assign mul_a = din0;
      assign mul_b = din1;
    end else begin : g_in_reg
      logic [PROD_W:0] in_q;
      fir_mul_pipe_reg #(.WIDTH(PROD_W + 1)) u_in_reg (
        .clk_i  (ap_clk),
        .rst_ni (ap_rst_n),
        .en_i   (adv),
        .d_i    ({in_valid, din0, din1}),
        .q_o    (in_q)
      );
      assign mul_v = in_q[PROD_W];
      assign mul_a = in_q[PROD_W-1 -: DIN0_WIDTH];
      assign mul_b = in_q[DIN1_WIDTH-1:0];
    end

    // Registered exact product; the multiply gets a full cycle.
    fir_mul_pipe_reg #(.WIDTH(PROD_W + 1)) u_prod_reg (
      .clk_i  (ap_clk),
      .rst_ni (ap_rst_n),
      .en_i   (adv),
      .d_i    ({mul_v, PROD_W'(mul_a) * PROD_W'(mul_b)}),
      .q_o    (dly_q[0])
    );

    // Extra latency is spent on the product, before the scaling logic.
    for (genvar gi = 0; gi < NUM_DLY; gi++) begin : g_dly
      fir_mul_pipe_reg #(.WIDTH(PROD_W + 1)) u_dly_reg (
        .clk_i  (ap_clk),
        .rst_ni (ap_rst_n),
        .en_i   (adv),
        .d_i    (dly_q[gi]),
        .q_o    (dly_q[gi+1])
      );
    end

    assign sc_v = dly_q[NUM_DLY][PROD_W];
    assign sc_p = dly_q[NUM_DLY][PROD_W-1:0];
  end

  // Scale, round and saturate/wrap the product ahead of the output register.
  sat_res_t             res;
  logic signed [MW-1:0] sc_ext;
  logic                 unused_res_hi;
  assign sc_ext        = MW'(sc_p);
  assign res           = sat_shift(sc_ext, SHIFT, ROUND_EN != 0, SAT_EN != 0, DOUT_WIDTH);
  assign unused_res_hi = ^res.dout[MW-1:DOUT_WIDTH];

  logic [OUT_W-1:0] out_q;
  fir_mul_pipe_reg #(.WIDTH(OUT_W)) u_out_reg (
    .clk_i  (ap_clk),
    .rst_ni (ap_rst_n),
    .en_i   (adv),
    .d_i    ({sc_v, res.ovf, res.dout[DOUT_WIDTH-1:0]}),
    .q_o    (out_q)
  );

  assign out_valid = out_q[OUT_W-1];
  assign dout_ovf  = out_q[DOUT_WIDTH];
  assign dout      = out_q[DOUT_WIDTH-1:0];

  logic sticky_q;
  logic sticky_d;

  // Sticky overflow: an accepted ovf result sets it and beats a clear.
  always_comb begin
    sticky_d = sticky_q;
    if (out_valid && out_ready && dout_ovf) begin
      sticky_d = 1'b1;
    end else if (ovf_clr) begin
      sticky_d = 1'b0;
    end
  end

  // Sticky flag register.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_fir_mul_pipe.sv
// Bench for fir_mul_pipe: four differently parametrised instances share one
// stimulus bus; each has its own scoreboard fed by an arithmetic model.
module tb_fir_mul_pipe;

  localparam int NI = 4;
  localparam int NS [NI] = '{3, 1, 2, 5};
  localparam int DW [NI] = '{23, 16, 16, 16};
  localparam int SH [NI] = '{0, 6, 6, 6};
  localparam int RE [NI] = '{0, 0, 1, 1};
  localparam int SE [NI] = '{1, 1, 0, 1};

  typedef struct {
    longint d;
    bit     o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        ovf_clr;
  logic [15:0] din0;
  logic [6:0]  din1;

  logic        rdy_a [NI];
  logic        ov_a  [NI];
  logic        ovf_a [NI];
  logic        stk_a [NI];
  logic [63:0] dout_a [NI];
  logic [22:0] dout0;
  logic [15:0] dout1, dout2, dout3;

  int          n_assert = 0;
  int          n_fail   = 0;
  exp_t        sb [NI][$];
  bit          stk_m [NI];
  bit          acc [NI];
  longint      seq0 [$];
  logic [63:0] cap_d [NI];
  logic        cap_o [NI];

  always #5 clk = ~clk;

  fir_mul_pipe #(.DOUT_WIDTH(23), .NUM_STAGE(3), .SHIFT(0), .ROUND_EN(0), .SAT_EN(1)) u0 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a[0]),
    .din0(din0), .din1(din1), .out_valid(ov_a[0]), .out_ready(out_ready),
    .dout(dout0), .dout_ovf(ovf_a[0]), .ovf_sticky(stk_a[0]), .ovf_clr(ovf_clr));
  fir_mul_pipe #(.DOUT_WIDTH(16), .NUM_STAGE(1), .SHIFT(6), .ROUND_EN(0), .SAT_EN(1)) u1 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a[1]),
    .din0(din0), .din1(din1), .out_valid(ov_a[1]), .out_ready(out_ready),
    .dout(dout1), .dout_ovf(ovf_a[1]), .ovf_sticky(stk_a[1]), .ovf_clr(ovf_clr));
  fir_mul_pipe #(.DOUT_WIDTH(16), .NUM_STAGE(2), .SHIFT(6), .ROUND_EN(1), .SAT_EN(0)) u2 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a[2]),
    .din0(din0), .din1(din1), .out_valid(ov_a[2]), .out_ready(out_ready),
    .dout(dout2), .dout_ovf(ovf_a[2]), .ovf_sticky(stk_a[2]), .ovf_clr(ovf_clr));
  fir_mul_pipe #(.DOUT_WIDTH(16), .NUM_STAGE(5), .SHIFT(6), .ROUND_EN(1), .SAT_EN(1)) u3 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a[3]),
    .din0(din0), .din1(din1), .out_valid(ov_a[3]), .out_ready(out_ready),
    .dout(dout3), .dout_ovf(ovf_a[3]), .ovf_sticky(stk_a[3]), .ovf_clr(ovf_clr));

  assign dout_a[0] = 64'($signed(dout0));
  assign dout_a[1] = 64'($signed(dout1));
  assign dout_a[2] = 64'($signed(dout2));
  assign dout_a[3] = 64'($signed(dout3));

  // Reference: exact product, optional +half, floor division by 2^SHIFT,
  // then clamp or modular wrap into the signed output range.
  function automatic longint mdl(input int i, input longint a, input longint b, output bit ovf);
    longint p, d, s, hi, lo, m;
    p = a * b;
    if (RE[i] != 0 && SH[i] > 0) p = p + (longint'(1) << (SH[i] - 1));
    d = longint'(1) << SH[i];
    s = p / d;
    if ((p % d) != 0 && p < 0) s = s - 1;
    hi = (longint'(1) << (DW[i] - 1)) - 1;
    lo = -hi - 1;
    ovf = (s > hi) || (s < lo);
    if (!ovf) return s;
    if (SE[i] != 0) return (s > hi) ? hi : lo;
    m = longint'(1) << DW[i];
    return (((s - lo) % m) + m) % m + lo;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // One clock: inputs were set before the call; score transfers and
  // acceptances just before the edge, then check sticky flags after it.
  task automatic step();
    bit   xfer;
    bit   eo;
    exp_t e;
    #1;
    for (int i = 0; i < NI; i++) begin
      acc[i] = 1'b0;
      eo     = 1'b0;
      xfer   = rst_n && ov_a[i] && out_ready;
      if (xfer) begin
        chk($sformatf("u%0d_has_expected", i), 64'(sb[i].size() != 0), 64'd1);
        if (sb[i].size() != 0) begin
          e  = sb[i].pop_front();
          eo = e.o;
          chk($sformatf("u%0d_dout", i), dout_a[i], 64'(e.d));
          chk($sformatf("u%0d_ovf", i), 64'(ovf_a[i]), 64'(e.o));
          $display("u%0d result dout=%0d ovf=%0d (exp %0d/%0d)", i, $signed(dout_a[i]), ovf_a[i], e.d, e.o);
          if (i == 0) seq0.push_back(longint'(dout_a[i]));
        end
      end
      if (!rst_n) stk_m[i] = 1'b0;
      else if (xfer && eo) stk_m[i] = 1'b1;
      else if (ovf_clr) stk_m[i] = 1'b0;
      if (rst_n && in_valid && rdy_a[i]) begin
        acc[i] = 1'b1;
        e.d = mdl(i, longint'($signed(din0)), longint'($signed(din1)), e.o);
        sb[i].push_back(e);
      end
      if (!rst_n) sb[i].delete();
    end
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) chk($sformatf("u%0d_sticky", i), 64'(stk_a[i]), 64'(stk_m[i]));
  endtask

  // One operand pair into empty pipelines; verify exact latency and capture results.
  task automatic single(input logic [15:0] a, input logic [6:0] b);
    din0 = a; din1 = b; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("lat_u%0d_c%0d", i, n), 64'(ov_a[i]), 64'(n == NS[i]));
        if (n == NS[i]) begin
          cap_d[i] = dout_a[i];
          cap_o[i] = ovf_a[i];
        end
      end
      step();
    end
  endtask

  initial begin
    int k;
    int nacc;
    bit stalled;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0; din0 = '0; din1 = '0;
    for (int i = 0; i < NI; i++) stk_m[i] = 1'b0;
    step();
    step();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_valid_u%0d", i), 64'(ov_a[i]), 64'd0);
      chk($sformatf("rst_dout_u%0d", i), dout_a[i], 64'd0);
      chk($sformatf("rst_ovf_u%0d", i), 64'(ovf_a[i]), 64'd0);
      chk($sformatf("rst_ready_u%0d", i), 64'(rdy_a[i]), 64'd1);
    end
    rst_n = 1'b1;

    // Extreme operands: exact at full width, saturates or wraps at 16 bits.
    single(16'h8000, 7'h40);
    chk("t1_u0_dout", cap_d[0], 64'd2097152);
    chk("t1_u0_ovf", 64'(cap_o[0]), 64'd0);
    chk("t2_u1_dout", cap_d[1], 64'd32767);
    chk("t2_u1_ovf", 64'(cap_o[1]), 64'd1);
    chk("t2_u1_sticky", 64'(stk_a[1]), 64'd1);
    chk("t2_u2_wrap", cap_d[2], 64'(-32768));
    chk("t2_u2_ovf", 64'(cap_o[2]), 64'd1);
    single(16'h7FFF, 7'h3F);
    chk("t2_u0_pos", cap_d[0], 64'd2064321);
    chk("t2_u1_pos", cap_d[1], 64'd32255);
    chk("t2_u1_pos_ovf", 64'(cap_o[1]), 64'd0);
    single(16'd100, 7'd3);
    chk("t3_trunc_pos", cap_d[1], 64'd4);
    chk("t3_round_pos", cap_d[2], 64'd5);
    chk("t3_round_pos_u3", cap_d[3], 64'd5);
    single(16'hFF9C, 7'd3);
    chk("t3_trunc_neg", cap_d[1], 64'(-5));
    chk("t3_round_neg", cap_d[2], 64'(-5));

    // Stream 1..8 through u0 with a 4-cycle stall after the first result.
    seq0.delete();
    k = 1; stalled = 1'b0;
    for (int c = 0; c < 60; c++) begin
      in_valid = (k <= 8); din0 = 16'(k); din1 = 7'd1;
      if (!stalled && ov_a[0]) begin
        stalled = 1'b1;
        out_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
          step();
          chk("t4_stall_ready", 64'(rdy_a[0]), 64'd0);
          chk("t4_stall_valid", 64'(ov_a[0]), 64'd1);
          chk("t4_stall_dout", dout_a[0], 64'd1);
        end
        out_ready = 1'b1;
      end
      step();
      if (acc[0]) k++;
    end
    chk("t4_count", 64'(seq0.size()), 64'd8);
    for (int j = 0; j < 8; j++) begin
      if (j < seq0.size()) chk($sformatf("t4_order_%0d", j), 64'(seq0[j]), 64'(j + 1));
    end

    // Random valid/ready traffic against the scoreboards.
    nacc = 0;
    for (int c = 0; c < 6000 && nacc < 1000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      ovf_clr   = ($urandom_range(0, 9) == 0);
      din0 = 16'($urandom);
      din1 = 7'($urandom);
      if ($urandom_range(0, 7) == 0) din0 = 16'h8000;
      if ($urandom_range(0, 7) == 0) din1 = 7'h40;
      step();
      if (acc[0]) nacc++;
    end
    chk("t5_accepted", 64'(nacc), 64'd1000);
    in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    repeat (8) step();
    for (int i = 0; i < NI; i++) chk($sformatf("t5_drained_u%0d", i), 64'(sb[i].size()), 64'd0);

    // Reset with results in flight, then a clean result afterwards.
    in_valid = 1'b1; din0 = 16'h8000; din1 = 7'h40;
    repeat (3) step();
    chk("t6_sticky_before", 64'(stk_a[1]), 64'd1);
    rst_n = 1'b0; in_valid = 1'b0;
    step();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("t6_valid_u%0d", i), 64'(ov_a[i]), 64'd0);
      chk($sformatf("t6_dout_u%0d", i), dout_a[i], 64'd0);
      chk($sformatf("t6_ovf_u%0d", i), 64'(ovf_a[i]), 64'd0);
      chk($sformatf("t6_ready_u%0d", i), 64'(rdy_a[i]), 64'd1);
    end
    rst_n = 1'b1;
    single(16'd1000, 7'd5);
    chk("t6_post_u0", cap_d[0], 64'd5000);
    chk("t6_post_u1", cap_d[1], 64'd78);
    chk("t6_post_u3", cap_d[3], 64'd78);

    // Clear and set in the same cycle: the set wins.
    ovf_clr = 1'b1; in_valid = 1'b1; din0 = 16'h8000; din1 = 7'h40;
    step();
    in_valid = 1'b0;
    chk("t6_clr_pre", 64'(stk_a[1]), 64'd0);
    step();
    chk("t6_set_wins", 64'(stk_a[1]), 64'd1);
    ovf_clr = 1'b0;
    repeat (6) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
